// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_sb
// Description : 16 x 16-bit register file for the ID stage. It has two
//               combinational read ports and one write port, with same-cycle
//               write-to-read bypass. A per-register busy scoreboard flags
//               load-use hazards. R0 is hardwired to zero.
//
// Ports       : clk         - system clock, rising-edge state updates
//               rst         - asynchronous active-high reset
//               re0_addr    - read port 0 address
//               re1_addr    - read port 1 address
//               p0          - read port 0 data (src1 select mux, regSRC)
//               p1          - read port 1 data (ALU src0 path)
//               we          - write enable from WB
//               dst_addr    - write address
//               dst         - write data
//               claim       - mark claim_addr busy (late-result load issued)
//               claim_addr  - register being claimed
//               busy0/busy1 - port source still pending writeback
//               stall       - busy0 | busy1
//
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_sb #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] re0_addr,
    input  logic [ADDR_W-1:0] re1_addr,
    output logic [DATA_W-1:0] p0,
    output logic [DATA_W-1:0] p1,
    input  logic              we,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [DATA_W-1:0] dst,
    input  logic              claim,
    input  logic [ADDR_W-1:0] claim_addr,
    output logic              busy0,
    output logic              busy1,
    output logic              stall
);

    localparam int c_NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]     r_mem [c_NUM_REGS];
    logic [c_NUM_REGS-1:0] r_busy;

    // Writes and claims that target R0 have no effect.
    logic w_wr_en;
    logic w_claim_en;

    assign w_wr_en    = we    && (dst_addr   != '0);
    assign w_claim_en = claim && (claim_addr != '0);

    // ------------------------------------------------------------------------
    // Register storage. Entry 0 is cleared on reset and never written.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[dst_addr] <= dst;
        end
    end

    // ------------------------------------------------------------------------
    // Busy scoreboard. A claim takes priority over a writeback to the same
    // register: a new load has been issued for a register whose previous
    // value is only now returning. Claims and writebacks to different
    // registers both take effect.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy[0] <= 1'b0;
            for (int i = 1; i < c_NUM_REGS; i++) begin
                if (w_claim_en && (claim_addr == ADDR_W'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (w_wr_en && (dst_addr == ADDR_W'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read ports. A writeback to the address being read in the same cycle
    // forwards the write data and also clears the hazard. The value is
    // available now, even though the busy bit only drops at the edge.
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0] w_raddr [2];
    logic [DATA_W-1:0] w_rdata [2];
    logic              w_rbusy [2];

    assign w_raddr[0] = re0_addr;
    assign w_raddr[1] = re1_addr;

    generate
        for (genvar gp = 0; gp < 2; gp++) begin : g_rd_port
            logic w_hit;
            assign w_hit = we && (dst_addr == w_raddr[gp]);

            assign w_rdata[gp] = (w_raddr[gp] == '0) ? '0  :
                                 w_hit               ? dst :
                                                       r_mem[w_raddr[gp]];

            assign w_rbusy[gp] = r_busy[w_raddr[gp]] & ~w_hit;
        end
    endgenerate

    assign p0    = w_rdata[0];
    assign p1    = w_rdata[1];
    assign busy0 = w_rbusy[0];
    assign busy1 = w_rbusy[1];
    assign stall = w_rbusy[0] | w_rbusy[1];

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_sb
// Description : Self-checking bench for reg_file_sb. Each stimulus cycle
//               pushes its expected outputs onto a scoreboard queue. The
//               queue is drained and compared once the combinational outputs
//               have settled. Directed scenarios are followed by a random
//               phase whose expectations come from a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_sb;

    logic        clk;
    logic        rst;
    logic [3:0]  re0_addr, re1_addr, dst_addr, claim_addr;
    logic [15:0] p0, p1, dst;
    logic        we, claim, busy0, busy1, stall;

    reg_file_sb #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .re0_addr   (re0_addr),
        .re1_addr   (re1_addr),
        .p0         (p0),
        .p1         (p1),
        .we         (we),
        .dst_addr   (dst_addr),
        .dst        (dst),
        .claim      (claim),
        .claim_addr (claim_addr),
        .busy0      (busy0),
        .busy1      (busy1),
        .stall      (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] p0;
        logic [15:0] p1;
        logic        b0;
        logic        b1;
        logic        st;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Behavioural model for the random phase.
    logic [15:0] m_mem [16];
    logic        m_busy [16];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] a0, input logic [3:0] a1,
                         input logic w, input logic [3:0] da, input logic [15:0] d,
                         input logic c, input logic [3:0] ca);
        re0_addr   = a0;
        re1_addr   = a1;
        we         = w;
        dst_addr   = da;
        dst        = d;
        claim      = c;
        claim_addr = ca;
    endtask

    task automatic push(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                        input logic b0, input logic b1, input logic st);
        exp_t e;
        e.tag = tag; e.p0 = e0; e.p1 = e1; e.b0 = b0; e.b1 = b1; e.st = st;
        sb_q.push_back(e);
    endtask

    // Let combinational outputs settle, then compare everything queued.
    task automatic drain();
        exp_t e;
        #2;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.tag, ".p0"},    p0,            e.p0);
            check({e.tag, ".p1"},    p1,            e.p1);
            check({e.tag, ".busy0"}, {15'd0, busy0}, {15'd0, e.b0});
            check({e.tag, ".busy1"}, {15'd0, busy1}, {15'd0, e.b1});
            check({e.tag, ".stall"}, {15'd0, stall}, {15'd0, e.st});
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle, queue its expectations, compare, and advance past the edge.
    task automatic cyc(input string tag,
                       input logic [3:0] a0, input logic [3:0] a1,
                       input logic w, input logic [3:0] da, input logic [15:0] d,
                       input logic c, input logic [3:0] ca,
                       input logic [15:0] e0, input logic [15:0] e1,
                       input logic b0, input logic b1, input logic st);
        drive(a0, a1, w, da, d, c, ca);
        push(tag, e0, e1, b0, b1, st);
        drain();
        next_edge();
    endtask

    task automatic rand_cycle(input int idx);
        logic [3:0]  a0, a1, da, ca;
        logic [15:0] d, e0, e1;
        logic        w, c, h0, h1, b0, b1;
        a0 = 4'($urandom_range(0, 5));
        a1 = 4'($urandom_range(0, 5));
        da = 4'($urandom_range(0, 5));
        ca = 4'($urandom_range(0, 5));
        d  = 16'($urandom);
        w  = 1'($urandom_range(0, 1));
        c  = 1'($urandom_range(0, 2) == 0);
        h0 = w && (da == a0);
        h1 = w && (da == a1);
        e0 = (a0 == 4'd0) ? 16'h0000 : (h0 ? d : m_mem[a0]);
        e1 = (a1 == 4'd0) ? 16'h0000 : (h1 ? d : m_mem[a1]);
        b0 = m_busy[a0] && !h0;
        b1 = m_busy[a1] && !h1;
        drive(a0, a1, w, da, d, c, ca);
        push($sformatf("rnd%0d", idx), e0, e1, b0, b1, b0 | b1);
        drain();
        if (w && da != 4'd0) begin
            m_mem[da] = d;
            if (!(c && ca == da)) m_busy[da] = 1'b0;
        end
        if (c && ca != 4'd0) m_busy[ca] = 1'b1;
        next_edge();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drive(4'd0, 4'd0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
        next_edge();

        // Reset: every address on both ports reads zero, nothing busy.
        for (int a = 0; a < 16; a++) begin
            drive(4'(a), 4'(15 - a), 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
            push($sformatf("rst_rd%0d", a), 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
            drain();
        end
        rst = 1'b0;
        next_edge();

        //  tag          a0    a1    we    da    dst        cl    ca     p0        p1        b0    b1    st
        cyc("wr5_byp",   4'd0, 4'd5, 1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        cyc("rd5",       4'd5, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 1'b0);
        cyc("wr0",       4'd0, 4'd0, 1'b1, 4'd0, 16'h1234, 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        cyc("cl0",       4'd0, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        cyc("rd0_after", 4'd0, 4'd5, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        cyc("cl3",       4'd0, 4'd3, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        cyc("busy3",     4'd0, 4'd3, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
        cyc("wb3_byp",   4'd0, 4'd3, 1'b1, 4'd3, 16'h00A5, 1'b0, 4'd0, 16'h0000, 16'h00A5, 1'b0, 1'b0, 1'b0);
        cyc("after_wb3", 4'd0, 4'd3, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 16'h00A5, 1'b0, 1'b0, 1'b0);
        cyc("cl_wr7",    4'd7, 4'd0, 1'b1, 4'd7, 16'h7777, 1'b1, 4'd7, 16'h7777, 16'h0000, 1'b0, 1'b0, 1'b0);
        cyc("rd7_busy",  4'd7, 4'd7, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h7777, 16'h7777, 1'b1, 1'b1, 1'b1);
        cyc("wr9_cl2",   4'd0, 4'd0, 1'b1, 4'd9, 16'hFFFF, 1'b1, 4'd2, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Reset pulse between edges clears storage and scoreboard immediately.
        drive(4'd9, 4'd2, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);
        push("pre_rst", 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b1);
        drain();
        rst = 1'b1;
        push("in_rst", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        drain();
        rst = 1'b0;
        next_edge();
        cyc("post_rst",  4'd9, 4'd7, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Reset held across an edge discards a pending write and claim.
        drive(4'd0, 4'd0, 1'b1, 4'd4, 16'hABCD, 1'b1, 4'd6);
        rst = 1'b1;
        next_edge();
        rst = 1'b0;
        cyc("rst_discard", 4'd4, 4'd6, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Random phase against the behavioural model (state is all-zero here).
        for (int i = 0; i < 16; i++) begin
            m_mem[i]  = 16'h0000;
            m_busy[i] = 1'b0;
        end
        for (int i = 0; i < 300; i++) begin
            rand_cycle(i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- 16-entry x 16-bit register file with two combinational read ports, one write port, and write-to-read bypass.
- Includes a per-register busy scoreboard for load-use stall detection.
- Sits in ID, directly upstream of the EX source-select muxes. p0 feeds the regSRC input of the src1 immediate/register selector; p1 feeds the ALU src0 path.
- R0 is hardwired to zero.

Parameters:
- DATA_W, 16, register and port data width.
- ADDR_W, 4, register address width (2**ADDR_W entries).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- re0_addr  input  4  read port 0 address.
- re1_addr  input  4  read port 1 address.
- p0  output  16  read port 0 data (to src1 select mux regSRC).
- p1  output  16  read port 1 data.
- we  input  1  write enable from WB stage.
- dst_addr  input  4  write address.
- dst  input  16  write data.
- claim  input  1  ID issues an instruction whose result arrives late (load); marks the destination busy.
- claim_addr  input  4  destination being claimed.
- busy0  output  1  port 0 source is pending (not yet written back).
- busy1  output  1  port 1 source is pending.
- stall  output  1  busy0 | busy1, to hazard unit / PC hold.

Behaviour:
- Reset: asynchronous on rst high.
  - All 16 registers clear to 0x0000; all busy bits clear to 0.
  - Outputs follow combinationally: p0 = p1 = 0x0000, busy0 = busy1 = stall = 0.
  - Reset asserted mid-write or mid-claim discards that write/claim.
- Write: on posedge clk, if we && dst_addr != 0, mem[dst_addr] <= dst. Writes to R0 are dropped; R0 always reads 0x0000.
- Read: combinational, zero cycle latency. For each port n:
  - addr == 0 -> 0x0000;
  - else if we && dst_addr == addr -> dst (same-cycle bypass);
  - else mem[addr].
- Both ports may read the same address; both return identical data.
- Scoreboard: busy[15:0], busy[0] is constant 0. On posedge clk, in this priority order:
  - claim && claim_addr != 0 -> busy[claim_addr] <= 1;
  - we && dst_addr != 0 -> busy[dst_addr] <= 0 (unless the same address is claimed this cycle);
  - simultaneous claim and write to different addresses: both take effect.
- Same-address claim and write in one cycle:
  - the claim wins and the bit ends at 1 (new load issued for a reg being written back);
  - the write still updates mem.
- busyN = busy[re{N}_addr] & ~(we && dst_addr == re{N}_addr); a writeback in the same cycle releases the hazard via bypass.
- stall = busy0 | busy1. The block does not suppress claim while stall is high; the hazard unit gates claim.
- No X on outputs for any address after reset.

Test Plan:
- Reset then read all addresses on both ports -> p0 = p1 = 0x0000, stall = 0.
- Write R5 = 0xBEEF (we = 1, one cycle), then re0_addr = 5 next cycle -> p0 = 0xBEEF. In the write cycle itself, with re1_addr = 5, p1 = 0xBEEF via bypass.
- Write R0 = 0x1234, then read R0 on both ports -> 0x0000. claim on R0 -> busy0 stays 0.
- Claim R3, next cycle read R3 on port 1 -> busy1 = 1, stall = 1.
  - Next cycle write R3 = 0x00A5 -> busy1 = 0 that cycle, p1 = 0x00A5.
  - Following cycle still busy1 = 0.
- Same cycle: claim R7 and write R7 = 0x7777 -> after the edge, mem[7] = 0x7777 and busy[7] = 1 (read R7 -> stall = 1).
- Write R9 = 0xFFFF and claim R2, then pulse rst between edges -> immediately p(R9) = 0x0000 and busy for R2 = 0. After release, the first edge with we = 0 keeps everything zero.
